// File: rtl/tm1638_pkg.sv
// Shared types and constants for the TM1638 responder: FSM encoding,
// command-group and read/write mode codes, display RAM geometry.
package tm1638_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  localparam logic [1:0] GRP_DATA = 2'b01;
  localparam logic [1:0] GRP_DISP = 2'b10;
  localparam logic [1:0] GRP_ADDR = 2'b11;

  localparam logic [1:0] RW_WRITE = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b10;

  localparam int RAM_DEPTH = 16;
  localparam int KEY_BITS  = 32;

  // Serial bytes arrive LSB first, so new bits enter at the top.
  function automatic logic [7:0] shift_lsb_first(input logic [7:0] sh, input logic b);
    return {b, sh[7:1]};
  endfunction

endpackage

// File: rtl/tm1638_edge_sync.sv
// Input sampler for one host line: STAGES flops (reset to 1) followed by a
// one-cycle-delayed copy used for rise/fall detection.
module tm1638_edge_sync
  import tm1638_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic primed
);

  logic [STAGES-1:0] sync;
  logic [STAGES-1:0] fill;
  logic              prev;

  // Sample pipeline plus a fill marker showing when level holds a real sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      fill <= '0;
      prev <= 1'b1;
    end else begin
      sync[0] <= din;
      fill[0] <= 1'b1;
      for (int i = 1; i < STAGES; i++) begin
        sync[i] <= sync[i-1];
        fill[i] <= fill[i-1];
      end
      prev <= sync[STAGES-1];
    end
  end

  assign level  = sync[STAGES-1];
  assign rise   = level & ~prev;
  assign fall   = ~level & prev;
  assign primed = fill[STAGES-1];

endmodule

// File: rtl/tm1638_responder.sv
// TM1638-style serial responder: decodes host commands, holds 16-byte display
// RAM, display settings and shifts out key data. Macro TM1638_RESP_SYNC_EN
// selects a SYNC_STAGES-deep synchronizer instead of a single input register.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        sclk_in,
  input  logic        dio_in,
  output logic        dio_out,
  output logic        dio_oe,
  input  logic [31:0] key_data,
  input  logic [3:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        disp_on,
  output logic [2:0]  brightness,
  output logic        frame_done,
  output logic        cmd_err
);

`ifdef TM1638_RESP_SYNC_EN
  localparam int SYNC_DEPTH = SYNC_STAGES;
`else
  localparam int SYNC_DEPTH = (SYNC_STAGES >= 1) ? 1 : 1;
`endif

  logic stb_lvl, stb_rise, stb_fall, stb_primed;
  logic sclk_lvl, sclk_rise, sclk_fall, sclk_primed;
  logic dio_lvl, dio_rise, dio_fall, dio_primed;
  logic unused_edges;

  tm1638_edge_sync #(.STAGES(SYNC_DEPTH)) u_stb_sync (
    .clk(clk), .rst(rst), .din(stb),
    .level(stb_lvl), .rise(stb_rise), .fall(stb_fall), .primed(stb_primed)
  );

  tm1638_edge_sync #(.STAGES(SYNC_DEPTH)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk_in),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall), .primed(sclk_primed)
  );

  tm1638_edge_sync #(.STAGES(SYNC_DEPTH)) u_dio_sync (
    .clk(clk), .rst(rst), .din(dio_in),
    .level(dio_lvl), .rise(dio_rise), .fall(dio_fall), .primed(dio_primed)
  );

  assign unused_edges = ^{sclk_lvl, sclk_primed, dio_rise, dio_fall, dio_primed};

  state_t       state, state_nx;
  logic [2:0]   bit_cnt;
  logic [7:0]   shreg;
  logic [3:0]   ptr;
  logic         fixed_addr;
  logic [7:0]   ram [RAM_DEPTH];
  logic [31:0]  key_lat;
  logic [5:0]   rd_cnt;
  logic         armed;

  logic [7:0]   byte_val;
  logic         take_bit, ram_we, ptr_load, mode_load, key_load, disp_load;
  logic         err, rd_shift, rd_end, frame_start;

  // A frame only opens on a falling stb seen after stb was observed high.
  assign frame_start = stb_fall & armed;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and per-cycle datapath strobes; stb edges take priority.
  always_comb begin
    state_nx  = state;
    byte_val  = shift_lsb_first(shreg, dio_lvl);
    take_bit  = 1'b0;
    ram_we    = 1'b0;
    ptr_load  = 1'b0;
    mode_load = 1'b0;
    key_load  = 1'b0;
    disp_load = 1'b0;
    err       = 1'b0;
    rd_shift  = 1'b0;
    rd_end    = 1'b0;
    if (stb_rise) begin
      state_nx = ST_IDLE;
    end else if (frame_start) begin
      state_nx = ST_CMD;
    end else if (!stb_lvl && sclk_rise && (state == ST_CMD || state == ST_WRITE)) begin
      take_bit = 1'b1;
      if (bit_cnt == 3'd7 && state == ST_CMD) begin
        case (byte_val[7:6])
          GRP_DATA: begin
            if (byte_val[1:0] == RW_WRITE) begin
              mode_load = 1'b1;
              state_nx  = ST_WRITE;
            end else if (byte_val[1:0] == RW_READ) begin
              mode_load = 1'b1;
              key_load  = 1'b1;
              state_nx  = ST_READ;
            end else begin
              err      = 1'b1;
              state_nx = ST_IDLE;
            end
          end
          GRP_ADDR: begin
            ptr_load = 1'b1;
            state_nx = ST_WRITE;
          end
          GRP_DISP: begin
            disp_load = 1'b1;
            state_nx  = ST_IDLE;
          end
          default: begin
            err      = 1'b1;
            state_nx = ST_IDLE;
          end
        endcase
      end else if (bit_cnt == 3'd7) begin
        ram_we = 1'b1;
      end else begin
        ram_we = 1'b0;
      end
    end else if (!stb_lvl && state == ST_READ) begin
      if (sclk_fall && rd_cnt < 6'd32) begin
        rd_shift = 1'b1;
      end else if (sclk_rise && rd_cnt == 6'd32) begin
        rd_end   = 1'b1;
        state_nx = ST_IDLE;
      end else begin
        rd_shift = 1'b0;
      end
    end else begin
      state_nx = state;
    end
  end

  // Shift register, pointer, RAM, settings and serial output.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      ptr        <= 4'd0;
      fixed_addr <= 1'b0;
      for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= 8'h00;
      key_lat    <= 32'h0000_0000;
      rd_cnt     <= 6'd0;
      disp_on    <= 1'b0;
      brightness <= 3'd0;
      dio_oe     <= 1'b0;
      dio_out    <= 1'b1;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
      armed      <= 1'b0;
    end else begin
      frame_done <= stb_rise;
      cmd_err    <= err;
      if (stb_primed && stb_lvl) armed <= 1'b1;

      if (stb_rise || frame_start) begin
        bit_cnt <= 3'd0;
      end else if (take_bit) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= byte_val;
      end

      if (ram_we) ram[ptr] <= byte_val;
      if (ptr_load) begin
        ptr <= byte_val[3:0];
      end else if (ram_we && !fixed_addr) begin
        ptr <= ptr + 4'd1;
      end
      if (mode_load) fixed_addr <= byte_val[2];

      if (disp_load) begin
        disp_on    <= byte_val[3];
        brightness <= byte_val[2:0];
      end

      if (key_load) begin
        key_lat <= key_data;
        rd_cnt  <= 6'd0;
        dio_oe  <= 1'b1;
        dio_out <= 1'b1;
      end else if (stb_rise || rd_end) begin
        dio_oe  <= 1'b0;
        dio_out <= 1'b1;
      end else if (rd_shift) begin
        dio_out <= key_lat[rd_cnt[4:0]];
        rd_cnt  <= rd_cnt + 6'd1;
      end
    end
  end

  assign rd_data = ram[rd_addr];

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: write/read frames, display command,
// invalid command and aborted frames, with hand-computed expectations.
module tb_tm1638_responder;

  logic        clk = 1'b0;
  logic        rst, stb, sclk_in, dio_in;
  logic        dio_out, dio_oe;
  logic [31:0] key_data;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        disp_on;
  logic [2:0]  brightness;
  logic        frame_done, cmd_err;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int err_cnt = 0;

  tm1638_responder dut (
    .clk(clk), .rst(rst), .stb(stb), .sclk_in(sclk_in), .dio_in(dio_in),
    .dio_out(dio_out), .dio_oe(dio_oe), .key_data(key_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .disp_on(disp_on),
    .brightness(brightness), .frame_done(frame_done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (cmd_err) err_cnt <= err_cnt + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sclk_in = 1'b0;
      dio_in  = b[i];
      wait_clks(4);
      sclk_in = 1'b1;
      wait_clks(4);
    end
  endtask

  task automatic frame_start;
    stb = 1'b0;
    wait_clks(4);
  endtask

  task automatic frame_end;
    stb    = 1'b1;
    dio_in = 1'b1;
    wait_clks(6);
  endtask

  task automatic one_byte_frame(input logic [7:0] b);
    frame_start();
    send_bits(b, 8);
    frame_end();
  endtask

  task automatic read_ram(input logic [3:0] a, output logic [7:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    checks++;
    if (dio_oe !== 1'b0 || dio_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_dio: oe=%b out=%b, expected oe=0 out=1", dio_oe, dio_out);
    end
    checks++;
    if (disp_on !== 1'b0 || brightness !== 3'd0) begin
      errors++;
      $display("FAIL reset_disp: disp_on=%b brightness=%0d, expected 0 0", disp_on, brightness);
    end
    checks++;
    if (frame_done !== 1'b0 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: frame_done=%b cmd_err=%b, expected 0 0", frame_done, cmd_err);
    end
    for (int a = 0; a < 16; a++) begin
      read_ram(a[3:0], d);
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("FAIL reset_ram[%0d]: got %h expected 00", a, d);
      end
    end
  endtask

  task automatic test_write_auto;
    logic [7:0] d;
    int fd0;
    one_byte_frame(8'h40);
    fd0 = fd_cnt;
    frame_start();
    send_bits(8'hC3, 8);
    send_bits(8'hA5, 8);
    send_bits(8'h5A, 8);
    frame_end();
    read_ram(4'd3, d);
    checks++;
    if (d !== 8'hA5) begin errors++; $display("FAIL auto_ram3: got %h expected a5", d); end
    read_ram(4'd4, d);
    checks++;
    if (d !== 8'h5A) begin errors++; $display("FAIL auto_ram4: got %h expected 5a", d); end
    checks++;
    if (fd_cnt - fd0 !== 1) begin
      errors++;
      $display("FAIL auto_frame_done: pulses=%0d expected 1", fd_cnt - fd0);
    end
  endtask

  task automatic test_write_fixed;
    logic [7:0] d;
    one_byte_frame(8'h44);
    frame_start();
    send_bits(8'hCF, 8);
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    frame_end();
    read_ram(4'd15, d);
    checks++;
    if (d !== 8'h22) begin errors++; $display("FAIL fixed_ram15: got %h expected 22", d); end
    read_ram(4'd0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL fixed_ram0: got %h expected 00", d); end
  endtask

  task automatic test_write_wrap;
    logic [7:0] d;
    one_byte_frame(8'h40);
    frame_start();
    send_bits(8'hCF, 8);
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    frame_end();
    read_ram(4'd15, d);
    checks++;
    if (d !== 8'h11) begin errors++; $display("FAIL wrap_ram15: got %h expected 11", d); end
    read_ram(4'd0, d);
    checks++;
    if (d !== 8'h22) begin errors++; $display("FAIL wrap_ram0: got %h expected 22", d); end
  endtask

  task automatic test_read;
    logic [7:0] exp_b [4];
    logic [7:0] got;
    exp_b = '{8'h00, 8'hFF, 8'h01, 8'h80};
    key_data = 32'h8001_FF00;
    frame_start();
    send_bits(8'h42, 8);
    dio_in = 1'b1;
    wait_clks(4);
    checks++;
    if (dio_oe !== 1'b1 || dio_out !== 1'b1) begin
      errors++;
      $display("FAIL read_idle: oe=%b out=%b, expected oe=1 out=1", dio_oe, dio_out);
    end
    for (int k = 0; k < 4; k++) begin
      got = 8'h00;
      for (int i = 0; i < 8; i++) begin
        sclk_in = 1'b0;
        wait_clks(4);
        if (k == 3 && i == 7) begin
          checks++;
          if (dio_oe !== 1'b1) begin
            errors++;
            $display("FAIL read_oe_bit31: oe=%b expected 1", dio_oe);
          end
        end
        got[i] = dio_out;
        sclk_in = 1'b1;
        wait_clks(4);
      end
      checks++;
      if (got !== exp_b[k]) begin
        errors++;
        $display("FAIL read_byte%0d: got %h expected %h", k, got, exp_b[k]);
      end
    end
    checks++;
    if (dio_oe !== 1'b0) begin
      errors++;
      $display("FAIL read_oe_end: oe=%b expected 0", dio_oe);
    end
    frame_end();
  endtask

  task automatic test_display;
    int e0;
    e0 = err_cnt;
    one_byte_frame(8'h8C);
    checks++;
    if (disp_on !== 1'b1 || brightness !== 3'd4) begin
      errors++;
      $display("FAIL disp_set: disp_on=%b brightness=%0d, expected 1 4", disp_on, brightness);
    end
    checks++;
    if (err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL disp_no_err: cmd_err pulses=%0d expected 0", err_cnt - e0);
    end
    e0 = err_cnt;
    one_byte_frame(8'h20);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL bad_cmd_err: cmd_err pulses=%0d expected 1", err_cnt - e0);
    end
    checks++;
    if (disp_on !== 1'b1 || brightness !== 3'd4 || dio_oe !== 1'b0) begin
      errors++;
      $display("FAIL bad_cmd_hold: disp_on=%b brightness=%0d oe=%b, expected 1 4 0",
               disp_on, brightness, dio_oe);
    end
    e0 = err_cnt;
    one_byte_frame(8'h41);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL bad_data_err: cmd_err pulses=%0d expected 1", err_cnt - e0);
    end
  endtask

  task automatic test_abort_stb;
    logic [7:0] d;
    frame_start();
    send_bits(8'hC5, 8);
    send_bits(8'hFF, 4);
    frame_end();
    read_ram(4'd5, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL abort_stb_ram5: got %h expected 00", d); end
    read_ram(4'd3, d);
    checks++;
    if (d !== 8'hA5) begin errors++; $display("FAIL abort_stb_ram3: got %h expected a5", d); end
    checks++;
    if (dio_oe !== 1'b0) begin errors++; $display("FAIL abort_stb_oe: oe=%b expected 0", dio_oe); end
  endtask

  task automatic test_abort_rst;
    logic [7:0] d;
    frame_start();
    send_bits(8'hC6, 8);
    send_bits(8'hFF, 4);
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(6);
    send_bits(8'h8C, 8);
    frame_end();
    read_ram(4'd6, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL abort_rst_ram6: got %h expected 00", d); end
    checks++;
    if (disp_on !== 1'b0 || dio_oe !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst_stale_frame: disp_on=%b oe=%b, expected 0 0", disp_on, dio_oe);
    end
    frame_start();
    send_bits(8'hC6, 8);
    send_bits(8'h77, 8);
    frame_end();
    read_ram(4'd6, d);
    checks++;
    if (d !== 8'h77) begin errors++; $display("FAIL after_rst_write: got %h expected 77", d); end
  endtask

  initial begin
    rst      = 1'b1;
    stb      = 1'b1;
    sclk_in  = 1'b1;
    dio_in   = 1'b1;
    key_data = 32'h0000_0000;
    rd_addr  = 4'd0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(3);
    test_reset();
    test_write_auto();
    test_write_fixed();
    test_write_wrap();
    test_read();
    test_display();
    test_abort_stb();
    test_abort_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
